// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: a zero in2 bypasses the iteration loop.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state;
  logic [1:0]       op_r;
  logic             neg_q, neg_r, zero_b;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;

  logic [WIDTH:0]     add_sum, shifted;
  logic [WIDTH-1:0]   diff, mag1, mag2, q_fix, r_fix;
  logic               borrow, early;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // In IDLE, acc_lo/mcand hold the raw in1/in2 until PREP replaces them with magnitudes.
  always_comb begin
    add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    shifted  = {acc_hi, acc_lo[WIDTH-1]};
    borrow   = shifted < {1'b0, mcand};
    diff     = shifted[WIDTH-1:0] - mcand;
    mag1     = (op_r[0] && acc_lo[WIDTH-1]) ? -acc_lo : acc_lo;
    mag2     = (op_r[0] && mcand[WIDTH-1]) ? -mcand : mcand;
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = zero_b ? '1 : (neg_q ? -acc_lo : acc_lo);
    r_fix    = neg_r ? -acc_hi : acc_hi;
`ifdef MULDIV_EARLY_OUT_EN
    early    = (mcand == '0);
`else
    early    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      op_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zero_b <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            acc_lo <= in1;
            mcand  <= in2;
            busy   <= 1'b1;
            state  <= PREP;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        PREP: begin
          neg_q  <= op_r[0] & (acc_lo[WIDTH-1] ^ mcand[WIDTH-1]);
          neg_r  <= op_r[0] & acc_lo[WIDTH-1];
          zero_b <= (mcand == '0);
          acc_hi <= '0;
          if (op_r[1]) begin
            mcand  <= mag2;
            acc_lo <= mag1;
            // Early out parks the dividend magnitude as remainder so FIX restores in1.
            if (early) begin
              acc_hi <= mag1;
              acc_lo <= '0;
            end
          end else begin
            mcand  <= mag1;
            acc_lo <= mag2;
          end
          // Early out runs a single frozen ITER cycle, keeping done at N+3.
          cnt   <= early ? LAST : '0;
          state <= ITER;
        end
        ITER: begin
          if (!(early || zero_b && cnt == LAST && early)) begin
            if (op_r[1]) begin
              acc_hi <= borrow ? shifted[WIDTH-1:0] : diff;
              acc_lo <= {acc_lo[WIDTH-2:0], ~borrow};
            end else begin
              acc_hi <= add_sum[WIDTH:1];
              acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (op_r[1]) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (default WIDTH=32).
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] in1, in2, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_ZERO = 4;
`else
  localparam int LAT_ZERO = 35;
`endif

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input int e_lat);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".busy"}, {31'b0, busy_ok & busy}, 32'd1);
    check({tag, ".hi"}, hi, e_hi);
    check({tag, ".lo"}, lo, e_lo);
    // start raised in the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.hi", hi, 32'h0);
    check("rst.lo", lo, 32'h0);
    reset = 1'b0;

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 35);
    run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 35);
    run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 35);
    run_op("divu",      2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       35);
    run_op("divu_zero", 2'b10, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, LAT_ZERO);
    run_op("div_zero",  2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, LAT_ZERO);
    run_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 35);
    run_op("multu_zero",2'b00, 32'd5,        32'd0,        32'h0,        32'h0,        LAT_ZERO);

    // MTHI / MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h3C3C3C3C;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", hi, 32'hA5A5A5A5);
    check("mtlo", lo, 32'h3C3C3C3C);

    // Writes while busy are dropped; hi/lo hold until FIX
    start = 1'b1; op = 2'b01; in1 = 32'h00010000; in2 = 32'h00030000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    check("busy_wr.hi", hi, 32'hA5A5A5A5);
    check("busy_wr.lo", lo, 32'h3C3C3C3C);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("busy_wr.done", {31'b0, done}, 32'd1);
    check("busy_wr.rhi", hi, 32'h3);
    check("busy_wr.rlo", lo, 32'h0);
    @(negedge clk);

    // Reset partway through a MULT aborts it
    start = 1'b1; op = 2'b01; in1 = 32'h12345; in2 = 32'hFFFFFFF7;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.hi", hi, 32'h0);
    check("abort.lo", lo, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort.nodone", {31'b0, seen}, 32'd0);

    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    check("post_abort.mthi", hi, 32'hA5A5A5A5);
    check("post_abort.lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
